bit_serial_feeder: RTL
======================

BIT_SERIAL_FEEDER -- requirements
Module: bit_serial_feeder

Interface
REQ-001 SHALL: clk  in  1  clock; all state updates on posedge clk.
REQ-002 SHALL: rstn  in  1  reset; asynchronous, active-low.
REQ-003 SHALL: prec  in  2  precision (00=8b, 01=4b, 10=2b; 11 treated as 8b).
REQ-004 SHALL: in_valid  in  1  upstream operand pair present.
REQ-005 SHALL: in_ready  out  1  feeder can accept a pair (FIFO not full).
REQ-006 SHALL: in_act  in  8  activation word.
REQ-007 SHALL: in_wgt  in  8  packed weight word (one 8b, two 4b or four 2b sub-weights, low sub-weight first).
REQ-008 SHALL: out_en  out  1  serial beat valid; drives MAC enable.
REQ-009 SHALL: out_ready  in  1  downstream accepts beat; low = stall.
REQ-010 SHALL: out_act  out  8  activation of the word being serialized, constant for all 8 beats.
REQ-011 SHALL: out_wbit  out  1  current weight bit.
REQ-012 SHALL: out_idx  out  3  bit position 0..7 within the word.
REQ-013 SHALL: out_first / out_last  out  1 each  first / last (sign) bit of the current sub-weight.
REQ-014 SHALL: out_word_done  out  1  high on the beat with out_idx=7.
REQ-015 SHALL: busy  out  1  high when the shifter or FIFO holds data.

Function
REQ-016 SHALL: 2-entry operand FIFO {act, wgt}; push on in_valid&in_ready; in_ready = !full, with no same-cycle push-while-full even if popping.
REQ-017 SHALL: beat accepted = out_en&out_ready; on stall every out_* signal holds its value.
REQ-018 SHALL: FSM IDLE/SHIFT; IDLE: out_en=0; FIFO non-empty -> load head, out_idx=0, -> SHIFT.
REQ-019 SHALL: SHIFT: accepted beat with out_idx<7 -> out_idx+1; accepted beat with out_idx=7 -> load next head with no bubble if FIFO non-empty, else -> IDLE.
REQ-020 SHALL: bits are emitted LSB first; out_wbit = wgt[out_idx].
REQ-021 SHALL: with N = 8/4/2 per prec, out_first = (out_idx mod N == 0) and out_last = (out_idx mod N == N-1).
REQ-022 SHALL: prec is sampled at word load; a mid-word change takes effect on the next word only.
REQ-023 SHALL: latency: a pair pushed at cycle t into an idle, empty feeder gives out_en=1, out_idx=0 at cycle t+2 (one cycle FIFO write, one cycle load).
REQ-024 SHALL: a word is always 8 beats regardless of precision.

Reset
REQ-025 SHALL: while rstn is low: out_en, out_wbit, out_idx, out_first, out_last, out_word_done, busy, out_act = 0; in_ready = 1; FIFO empty; FSM IDLE.
REQ-026 SHALL: reset mid-word discards the shifter and FIFO contents immediately; the first push after release starts at out_idx=0.

Configuration
REQ-027 SHALL: macro BSF_PAIR_COUNT_EN defined -> extra output pair_cnt [15:0], cleared by reset, incremented on each accepted out_idx=7 beat, wrapping 0xFFFF->0.
REQ-028 SHALL: macro BSF_PAIR_COUNT_EN undefined -> no pair_cnt port and no counter logic.

Structure
REQ-029 SHALL: shared package bs_pkg holds the precision enum (PREC_8B/PREC_4B/PREC_2B), ACT_W=8, WGT_W=8, IDX_W=3 and the FSM state typedef.
REQ-030 SHALL: the FIFO is the single sub-module bs_operand_fifo (depth 2, width 16); the shifter and FSM stay in the top level.

Verification
REQ-031 SHALL: prec=00, act=0x67, wgt=0x0A -> out_wbit 0,1,0,1,0,0,0,0; out_act=0x67 on all beats; out_last only at idx7; out_first only at idx0.
REQ-032 SHALL: prec=01, wgt=0x48 -> out_wbit 0,0,0,1,0,0,1,0; out_first at idx 0,4; out_last at idx 3,7.
REQ-033 SHALL: prec=10, wgt=0x4E -> out_last at idx 1,3,5,7; out_first at idx 0,2,4,6.
REQ-034 SHALL: push 3 pairs back-to-back with out_ready=1 -> in_ready=0 once FIFO holds 2; 24 contiguous out_en beats, no bubble; out_word_done at beats 8,16,24; then IDLE, busy=0.
REQ-035 SHALL: out_ready=0 for 5 cycles at idx3 -> out_idx, out_wbit, out_last held; stream resumes at idx3, total 8 accepted beats.
REQ-036 SHALL: rstn low at idx5 with one pair queued -> all outputs 0 and in_ready=1 at once; after release the next push emits idx0 of the new word and the queued pair is lost.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial operand feeder: operand widths,
// precision encoding, FSM state type and the sub-weight mask helper.
package bs_pkg;

  localparam int ACT_W  = 8;
  localparam int WGT_W  = 8;
  localparam int IDX_W  = 3;
  localparam int PAIR_W = ACT_W + WGT_W;

  typedef enum logic [1:0] {
    PREC_8B = 2'b00,
    PREC_4B = 2'b01,
    PREC_2B = 2'b10
  } prec_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Mask selecting the bit position inside one sub-weight (N-1 for N-bit
  // sub-weights); the unused encoding 2'b11 falls back to 8-bit words.
  function automatic logic [IDX_W-1:0] prec_mask(input logic [1:0] p);
    logic [IDX_W-1:0] m;
    m = 3'd7;
    if (p == PREC_4B) m = 3'd3;
    else if (p == PREC_2B) m = 3'd1;
    return m;
  endfunction

endpackage

// File: rtl/bs_operand_fifo.sv
// Two-entry operand FIFO holding {act, wgt} pairs ahead of the shifter.
// Storage is not reset; only the occupancy/pointer state is.
module bs_operand_fifo
  import bs_pkg::*;
#(
  parameter int DATA_W = PAIR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign pop_data = mem[rd_ptr];

  // Write the incoming pair into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; push and pop may coincide.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bit_serial_feeder.sv
// Bit-serial operand feeder: queues {activation, packed weight} pairs and
// streams each weight LSB first, one bit per accepted beat, eight beats per
// word, with sub-weight first/last (sign) markers for the MAC.
// Optional feature: define BSF_PAIR_COUNT_EN to add the pair_cnt output,
// a wrapping count of completed words.
module bit_serial_feeder
  import bs_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       prec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACT_W-1:0] in_act,
  input  logic [WGT_W-1:0] in_wgt,
  output logic             out_en,
  input  logic             out_ready,
  output logic [ACT_W-1:0] out_act,
  output logic             out_wbit,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_first,
  output logic             out_last,
  output logic             out_word_done,
  output logic             busy
`ifdef BSF_PAIR_COUNT_EN
  ,
  output logic [15:0]      pair_cnt
`endif
);

  state_e            state;
  state_e            state_nxt;
  logic              load;
  logic              beat;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PAIR_W-1:0] fifo_dout;
  logic [ACT_W-1:0]  act_r;
  logic [WGT_W-1:0]  wgt_r;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  mask_r;
  logic              last_bit;

  // in_ready ignores a same-cycle pop so a full FIFO never takes a push.
  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & ~fifo_full;

  bs_operand_fifo #(.DATA_W(PAIR_W)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data ({in_act, in_wgt}),
    .pop       (load),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_en   = (state == ST_SHIFT);
  assign beat     = out_en & out_ready;
  assign last_bit = (idx_r == 3'd7);

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and word-load decision; back-to-back words load on the
  // final accepted beat so there is no bubble between them.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (beat && last_bit) begin
          if (!fifo_empty) load = 1'b1;
          else             state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shifter: capture the head pair and its precision at load, then step
  // the bit index on each accepted beat; 7 -> 0 wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_r  <= '0;
      wgt_r  <= '0;
      idx_r  <= '0;
      mask_r <= 3'd7;
    end else if (load) begin
      act_r  <= fifo_dout[PAIR_W-1:WGT_W];
      wgt_r  <= fifo_dout[WGT_W-1:0];
      idx_r  <= '0;
      mask_r <= prec_mask(prec);
    end else if (beat) begin
      idx_r  <= idx_r + 3'd1;
    end
  end

  assign out_act       = act_r;
  assign out_idx       = idx_r;
  assign out_wbit      = out_en & wgt_r[idx_r];
  assign out_first     = out_en & ((idx_r & mask_r) == 3'd0);
  assign out_last      = out_en & ((idx_r & mask_r) == mask_r);
  assign out_word_done = out_en & last_bit;
  assign busy          = out_en | ~fifo_empty;

`ifdef BSF_PAIR_COUNT_EN
  // Count completed words; wraps from 0xFFFF to 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                pair_cnt <= '0;
    else if (beat && last_bit) pair_cnt <= pair_cnt + 16'd1;
  end
`endif

endmodule
